// File: rtl/counter_seq_checker.sv
// Passive monitor for an up-counter: predicts the next count from the previous
// sample and enable, locks after a run of good predictions, and flags, counts
// and reports deviations and wraps while locked.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no valid previous sample yet; load reference only
// ST_SYNC  | comparing; counting consecutive correct predictions
// ST_LOCK  | tracking the counter; any deviation is reported as an error
module counter_seq_checker #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8,
   parameter int SYNC_LEN  = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     count_in,
   output logic                 locked,
   output logic                 mismatch,
   output logic [WIDTH-1:0]     expected,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 wrap_pulse
);

   localparam int MC_W = $clog2(SYNC_LEN + 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_SYNC  = 2'd1,
      ST_LOCK  = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [MC_W-1:0]      match_cnt, match_nxt, match_inc;
   logic [WIDTH-1:0]     ref_q, ref_nxt;
   logic                 en_q, en_nxt;
   logic [WIDTH-1:0]     pred;
   logic                 locked_nxt, mismatch_nxt, wrap_nxt;
   logic [WIDTH-1:0]     expected_nxt;
   logic [ERR_CNT_W-1:0] err_nxt;

   // State, reference sample and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_EMPTY;
         match_cnt  <= '0;
         ref_q      <= '0;
         en_q       <= 1'b0;
         locked     <= 1'b0;
         mismatch   <= 1'b0;
         expected   <= '0;
         err_count  <= '0;
         wrap_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         match_cnt  <= match_nxt;
         ref_q      <= ref_nxt;
         en_q       <= en_nxt;
         locked     <= locked_nxt;
         mismatch   <= mismatch_nxt;
         expected   <= expected_nxt;
         err_count  <= err_nxt;
         wrap_pulse <= wrap_nxt;
      end
   end

   // Prediction, compare and next-state decode
   always_comb begin
      pred         = ref_q + WIDTH'(en_q);
      match_inc    = match_cnt + MC_W'(1);
      state_nxt    = state;
      match_nxt    = match_cnt;
      ref_nxt      = count_in;
      en_nxt       = enable;
      mismatch_nxt = 1'b0;
      wrap_nxt     = 1'b0;
      expected_nxt = expected;
      err_nxt      = err_count;

      if (clear) begin
         state_nxt    = ST_EMPTY;
         match_nxt    = '0;
         ref_nxt      = '0;
         en_nxt       = 1'b0;
         expected_nxt = '0;
         err_nxt      = '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               state_nxt = ST_SYNC;
               match_nxt = '0;
            end
            ST_SYNC: begin
               expected_nxt = pred;
               if (count_in == pred) begin
                  match_nxt = match_inc;
                  if (match_inc == MC_W'(SYNC_LEN))
                     state_nxt = ST_LOCK;
               end else begin
                  match_nxt = '0;
               end
            end
            ST_LOCK: begin
               expected_nxt = pred;
               if (count_in != pred) begin
                  mismatch_nxt = 1'b1;
                  state_nxt    = ST_SYNC;
                  match_nxt    = '0;
                  if (err_count != '1)
                     err_nxt = err_count + ERR_CNT_W'(1);
               end else if ((ref_q == '1) && en_q && (count_in == '0)) begin
                  wrap_nxt = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
               match_nxt = '0;
            end
         endcase
      end

      locked_nxt = (state_nxt == ST_LOCK);
   end

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker. Two instances share stimulus: one with
// an 8-bit error counter, one with a 2-bit counter to exercise saturation.
module tb_counter_seq_checker;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] count_in = 4'd0;

   logic       locked, mismatch, wrap_pulse;
   logic [3:0] expected;
   logic [7:0] err_count;
   logic       locked_s, mismatch_s, wrap_pulse_s;
   logic [3:0] expected_s;
   logic [1:0] err_count_s;

   int checks = 0;
   int errors = 0;

   counter_seq_checker #(.WIDTH(4), .ERR_CNT_W(8), .SYNC_LEN(2)) dut (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .count_in(count_in), .locked(locked), .mismatch(mismatch),
      .expected(expected), .err_count(err_count), .wrap_pulse(wrap_pulse));

   counter_seq_checker #(.WIDTH(4), .ERR_CNT_W(2), .SYNC_LEN(2)) dut_s (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .count_in(count_in), .locked(locked_s), .mismatch(mismatch_s),
      .expected(expected_s), .err_count(err_count_s), .wrap_pulse(wrap_pulse_s));

   always #5 clock = ~clock;

   typedef struct {
      logic       lk;
      logic       mm;
      logic       wr;
      logic [3:0] ex;
      logic [7:0] er;
      logic [1:0] ers;
   } exp_t;

   exp_t sb[$];

   // Reference model: 0 empty, 1 sync, 2 lock
   int         m_st = 0;
   int         m_mc = 0;
   logic [3:0] m_ref = 4'd0;
   logic       m_en = 1'b0;
   logic [3:0] m_ex = 4'd0;
   logic [7:0] m_err = 8'd0;
   logic [1:0] m_errs = 2'd0;

   // Counter value the bench presents on the next edge
   logic [3:0] cnt = 4'd0;
   int mm_seen = 0;
   int mm_seen_s = 0;
   int wr_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_mc = 0; m_ref = 4'd0; m_en = 1'b0;
      m_ex = 4'd0; m_err = 8'd0; m_errs = 2'd0;
      sb.delete();
   endtask

   task automatic model_edge(input logic en, input logic [3:0] cin, input logic clr);
      exp_t e;
      logic [3:0] pred;
      e.mm = 1'b0;
      e.wr = 1'b0;
      if (clr) begin
         m_st = 0; m_mc = 0; m_ref = 4'd0; m_en = 1'b0;
         m_ex = 4'd0; m_err = 8'd0; m_errs = 2'd0;
      end else begin
         pred = m_ref + {3'd0, m_en};
         if (m_st == 0) begin
            m_st = 1;
            m_mc = 0;
         end else if (m_st == 1) begin
            m_ex = pred;
            if (cin == pred) begin
               m_mc++;
               if (m_mc == 2) m_st = 2;
            end else begin
               m_mc = 0;
            end
         end else begin
            m_ex = pred;
            if (cin != pred) begin
               e.mm = 1'b1;
               if (m_err != 8'hFF) m_err++;
               if (m_errs != 2'd3) m_errs++;
               m_st = 1;
               m_mc = 0;
            end else if (m_ref == 4'hF && m_en && cin == 4'd0) begin
               e.wr = 1'b1;
            end
         end
         m_ref = cin;
         m_en = en;
      end
      e.lk = (m_st == 2);
      e.ex = m_ex;
      e.er = m_err;
      e.ers = m_errs;
      sb.push_back(e);
   endtask

   // One edge: drive inputs, predict, then compare both instances after the edge
   task automatic drive(input logic en, input logic [3:0] cin, input logic clr);
      exp_t e;
      enable = en;
      count_in = cin;
      clear = clr;
      model_edge(en, cin, clr);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("locked", {31'd0, locked}, {31'd0, e.lk});
         chk("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
         chk("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, e.wr});
         chk("expected", {28'd0, expected}, {28'd0, e.ex});
         chk("err_count", {24'd0, err_count}, {24'd0, e.er});
         chk("locked_s", {31'd0, locked_s}, {31'd0, e.lk});
         chk("mismatch_s", {31'd0, mismatch_s}, {31'd0, e.mm});
         chk("err_count_s", {30'd0, err_count_s}, {30'd0, e.ers});
      end
      if (mismatch) mm_seen++;
      if (mismatch_s) mm_seen_s++;
      if (wrap_pulse) wr_seen++;
      clear = 1'b0;
   endtask

   // Well-behaved counter edge
   task automatic tick(input logic en);
      drive(en, cnt, 1'b0);
      cnt = cnt + {3'd0, en};
   endtask

   // Counter jumps to an unexpected value; it then continues from there
   task automatic deviate(input logic en, input logic [3:0] bad);
      drive(en, bad, 1'b0);
      cnt = bad + {3'd0, en};
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_expected", {28'd0, expected}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      cnt = 4'd0;

      // Lock after 1+SYNC_LEN edges, then a full wrap
      tick(1'b1);
      tick(1'b1);
      chk("not_locked_yet", {31'd0, locked}, 32'd0);
      tick(1'b1);
      chk("locked_after_3", {31'd0, locked}, 32'd1);
      wr_seen = 0;
      for (int i = 0; i < 16; i++) tick(1'b1);
      chk("one_wrap", wr_seen, 32'd1);
      chk("no_err_clean", {24'd0, err_count}, 32'd0);

      // Deviation while predicting 5, then re-lock on 8,9
      while (cnt != 4'd5) tick(1'b1);
      deviate(1'b1, 4'd7);
      chk("dev_expected", {28'd0, expected}, 32'd5);
      chk("dev_mismatch", {31'd0, mismatch}, 32'd1);
      chk("dev_err", {24'd0, err_count}, 32'd1);
      chk("dev_unlocked", {31'd0, locked}, 32'd0);
      tick(1'b1);
      chk("pulse_one_cycle", {31'd0, mismatch}, 32'd0);
      tick(1'b1);
      chk("relocked", {31'd0, locked}, 32'd1);
      chk("relock_expected", {28'd0, expected}, 32'd9);

      // Hold with enable low, then an illegal step
      tick(1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0);
      chk("hold_locked", {31'd0, locked}, 32'd1);
      chk("hold_err", {24'd0, err_count}, 32'd1);
      deviate(1'b0, cnt + 4'd1);
      chk("hold_step_mm", {31'd0, mismatch}, 32'd1);
      chk("hold_step_err", {24'd0, err_count}, 32'd2);
      tick(1'b1);
      tick(1'b1);

      // Asynchronous reset between edges while locked
      chk("pre_rst_locked", {31'd0, locked}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("arst_locked", {31'd0, locked}, 32'd0);
      chk("arst_err", {24'd0, err_count}, 32'd0);
      chk("arst_expected", {28'd0, expected}, 32'd0);
      chk("arst_locked_s", {31'd0, locked_s}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      cnt = 4'd0;
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      chk("arst_relock", {31'd0, locked}, 32'd1);

      // Five deviations: 2-bit counter saturates, pulses keep coming
      mm_seen = 0;
      mm_seen_s = 0;
      for (int i = 0; i < 5; i++) begin
         deviate(1'b1, cnt + 4'd3);
         tick(1'b1);
         tick(1'b1);
      end
      chk("sat_pulses", mm_seen, 32'd5);
      chk("sat_pulses_s", mm_seen_s, 32'd5);
      chk("sat_err_s", {30'd0, err_count_s}, 32'd3);
      chk("sat_err", {24'd0, err_count}, 32'd5);

      // Clear on the same edge as a deviation
      chk("pre_clr_locked", {31'd0, locked}, 32'd1);
      drive(1'b1, cnt + 4'd6, 1'b1);
      chk("clr_mismatch", {31'd0, mismatch}, 32'd0);
      chk("clr_err", {24'd0, err_count}, 32'd0);
      chk("clr_locked", {31'd0, locked}, 32'd0);
      cnt = 4'd2;
      tick(1'b1);
      tick(1'b1);
      chk("clr_empty_2", {31'd0, locked}, 32'd0);
      tick(1'b1);
      chk("clr_relock_3", {31'd0, locked}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
